bitonic_sort_ctrl: RTL and testbench
====================================

// Module: bitonic_sort_ctrl
// PURPOSE
//  Iterative 8-element bitonic sorter: one rank of four compare-exchange
//  units is reused over the six bitonic passes, sequenced by an FSM.
//  Sits between an upstream valid/ready source and a downstream consumer.
//  Trades the fully unrolled six-stage network for 1/6 of the comparator area.
// PARAMETERS
//  W      8   element width in bits; unsigned compare
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    input vector valid
//  in_ready   out  1    block can accept a vector
//  in_order   in   1    0 = ascending, 1 = descending; sampled on accept
//  in_data    in   8*W  element i at [W*i +: W]
//  out_valid  out  1    sorted vector available
//  out_ready  in   1    consumer accepts the vector
//  out_data   out  8*W  sorted result, element i at [W*i +: W]
//  busy       out  1    high in SORT or DONE
//  pass_idx   out  3    current pass 0..5; 0 outside SORT
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, pass_idx=0,
//   out_data=0, data register=0, order register=0.
//  FSM: IDLE -> SORT -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid&in_ready on an edge loads in_data and
//    in_order, sets pass=0, goes to SORT.
//   SORT: one pass per clock. pass 5 done -> DONE. in_ready=0.
//    in_valid is ignored.
//   DONE: out_valid=1, out_data=register. It holds stable until
//    out_ready=1. Then -> IDLE. No new vector is accepted in the same cycle.
//  Pass schedule (k = block, j = distance):
//   (2,1) (4,2) (4,1) (8,4) (8,2) (8,1).
//  Per pass, for each i with (i & j)==0, compare elements i and i^j.
//   Ascending pair: dir = ((i & k)==0) XOR order.
//   dir=1: put min at i and max at i^j. dir=0: put max at i.
//   For k=8, (i&k) is always 0, so the final merge follows order.
//  Equal elements: no swap. Data passes through unchanged.
//  Latency: accept edge T. Passes land on edges T+1..T+6.
//   out_valid=1 from edge T+6.
//   Throughput: one vector per 8 cycles (accept, 6 passes, handoff).
//  Reset mid-operation: any state returns to IDLE asynchronously.
//   The partial result is discarded. out_valid drops immediately.
//  out_ready while not in DONE: ignored.
//  in_valid held through SORT/DONE: not consumed. It is accepted on the
//   first IDLE edge.
// STRUCTURE
//  Shared package bitonic_pkg:
//   state enum {IDLE, SORT, DONE}.
//   pass-table constants PASS_K[0:5] and PASS_J[0:5].
//   NUM_PASS=6, NUM_ELEM=8.
//  Sub-module bitonic_cmp: a, b, dir -> lo, hi. Purely combinational.
//   It has four instances.
//  Pair routing: a mux per pass selects which register slots feed each
//   instance. The results write back to the same slots.
// TESTING
//  1 in_data={8,7,6,5,4,3,2,1} (elem0=8), order=0
//    -> out_data elem0..7 = 1..8. out_valid exactly 6 edges after accept.
//  2 Same data, order=1 -> elem0..7 = 8..1.
//    Then input {3,200,0,255,17,17,9,128}, order=0
//    -> {0,3,9,17,17,128,200,255}.
//  3 All elements 8'hA5 -> output identical to input. No X.
//    pass_idx steps 0..5.
//  4 out_ready low for 3 cycles in DONE -> out_data and out_valid hold.
//    in_ready=0 throughout. Release -> IDLE next edge.
//  5 rst_n low during pass 3 -> out_valid=0 and busy=0 immediately.
//    in_ready=1. The next vector sorts correctly.
//  6 in_valid held high, out_ready tied 1, 4 random vectors
//    -> accepts spaced 8 cycles apart. Every result matches the
//    reference model.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared types and pass schedule for the iterative 8-element bitonic sorter.
package bitonic_pkg;

    localparam int unsigned NUM_ELEM = 8;
    localparam int unsigned NUM_PASS = 6;
    localparam int unsigned NUM_CMP  = NUM_ELEM / 2;

    typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

    // Block size k and compare distance j for each of the six passes.
    localparam logic [3:0] PASS_K [NUM_PASS] = '{4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8};
    localparam logic [3:0] PASS_J [NUM_PASS] = '{4'd1, 4'd2, 4'd1, 4'd4, 4'd2, 4'd1};

    // Lower slot of comparator c: c with a zero inserted at the bit position of j.
    function automatic logic [2:0] pair_lo(input logic [1:0] c, input logic [3:0] j);
        case (j)
            4'd1:    return {c, 1'b0};
            4'd2:    return {c[1], 1'b0, c[0]};
            default: return {1'b0, c};
        endcase
    endfunction

endpackage

// File: rtl/bitonic_cmp.sv
// Combinational compare-exchange: dir=1 puts min on lo_o, dir=0 puts max on lo_o.
module bitonic_cmp #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         dir_i,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] hi_o
);

    logic swap;

    // Strict compares so equal elements never swap.
    assign swap = dir_i ? (a_i > b_i) : (a_i < b_i);
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Iterative 8-element bitonic sorter: four shared compare-exchange units,
// one pass per clock, valid/ready on both sides.
module bitonic_sort_ctrl
    import bitonic_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_order_i,
    input  logic [8*W-1:0]    in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [8*W-1:0]    out_data_o,
    output logic              busy_o,
    output logic [2:0]        pass_idx_o
);

    state_e           state_q;
    logic [8*W-1:0]   data_q;
    logic             order_q;
    logic [2:0]       pass_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [3:0]       pass_k;
    logic [3:0]       pass_j;
    logic [W-1:0]     elem    [NUM_ELEM];
    logic [W-1:0]     sorted  [NUM_ELEM];
    logic [2:0]       lo_idx  [NUM_CMP];
    logic [2:0]       hi_idx  [NUM_CMP];
    logic [W-1:0]     cmp_a   [NUM_CMP];
    logic [W-1:0]     cmp_b   [NUM_CMP];
    logic             cmp_dir [NUM_CMP];
    logic [W-1:0]     cmp_lo  [NUM_CMP];
    logic [W-1:0]     cmp_hi  [NUM_CMP];
    logic [8*W-1:0]   data_sorted;

    // Route the register slots of the current pass onto the shared comparators.
    always_comb begin
        pass_k = PASS_K[NUM_PASS-1];
        pass_j = PASS_J[NUM_PASS-1];
        if (pass_q < 3'(NUM_PASS)) begin
            pass_k = PASS_K[pass_q];
            pass_j = PASS_J[pass_q];
        end
        for (int e = 0; e < NUM_ELEM; e++) begin
            elem[e] = data_q[W*e +: W];
        end
        for (int c = 0; c < NUM_CMP; c++) begin
            lo_idx[c]  = pair_lo(2'(c), pass_j);
            hi_idx[c]  = lo_idx[c] ^ pass_j[2:0];
            cmp_a[c]   = elem[lo_idx[c]];
            cmp_b[c]   = elem[hi_idx[c]];
            cmp_dir[c] = (({1'b0, lo_idx[c]} & pass_k) == 4'd0) ^ order_q;
        end
    end

    for (genvar c = 0; c < NUM_CMP; c++) begin : g_cmp
        bitonic_cmp #(
            .W(W)
        ) u_cmp (
            .a_i   (cmp_a[c]),
            .b_i   (cmp_b[c]),
            .dir_i (cmp_dir[c]),
            .lo_o  (cmp_lo[c]),
            .hi_o  (cmp_hi[c])
        );
    end

    always_comb begin
        for (int e = 0; e < NUM_ELEM; e++) begin
            sorted[e] = elem[e];
        end
        for (int c = 0; c < NUM_CMP; c++) begin
            sorted[lo_idx[c]] = cmp_lo[c];
            sorted[hi_idx[c]] = cmp_hi[c];
        end
        for (int e = 0; e < NUM_ELEM; e++) begin
            data_sorted[W*e +: W] = sorted[e];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            order_q     <= 1'b0;
            pass_q      <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        data_q     <= in_data_i;
                        order_q    <= in_order_i;
                        pass_q     <= 3'd0;
                        state_q    <= StSort;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StSort: begin
                    data_q <= data_sorted;
                    if (pass_q == 3'(NUM_PASS - 1)) begin
                        pass_q      <= 3'd0;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        pass_q <= pass_q + 3'd1;
                    end
                end
                StDone: begin
                    // Return to IDLE only; the next vector is taken on the following edge.
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    pass_q      <= 3'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = data_q;
    assign busy_o      = busy_q;
    assign pass_idx_o  = pass_q;

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed and random checks of bitonic_sort_ctrl against a plain sorting model.
module tb_bitonic_sort_ctrl;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_order = 1'b0;
    logic [63:0]   in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [63:0]   out_data;
    logic          busy;
    logic [2:0]    pass_idx;

    int            checks = 0;
    int            errors = 0;
    logic [63:0]   exp_q [$];

    bitonic_sort_ctrl #(
        .W(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_order_i  (in_order),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy),
        .pass_idx_o  (pass_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [63:0] ref_sort(input logic [63:0] d, input logic ord);
        logic [7:0]  a [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) a[i] = d[8*i +: 8];
        for (int p = 0; p < 7; p++)
            for (int i = 0; i < 7 - p; i++)
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
        for (int i = 0; i < 8; i++) r[8*i +: 8] = ord ? a[7-i] : a[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [63:0] d, input logic ord,
                        input logic [63:0] exp);
        bit rdy;
        int n = 0;
        in_data  = d;
        in_order = ord;
        in_valid = 1'b1;
        do begin
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 20);
        check({tag, ".accept"}, 64'(rdy), 64'd1);
        in_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    // Called right after the accept edge; walks the passes and takes the result.
    task automatic recv(input string tag, input bit hold);
        int n = 0;
        logic [63:0] e;
        while (!out_valid && n < 20) begin
            check({tag, ".pass"}, 64'(pass_idx), 64'(n));
            check({tag, ".busy"}, 64'({busy, in_ready}), 64'b10);
            tick();
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'd6);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, ".data"}, out_data, e);
        if (hold) begin
            repeat (3) begin
                tick();
                check({tag, ".hold_data"}, out_data, e);
                check({tag, ".hold_flags"}, 64'({out_valid, in_ready, busy}), 64'b101);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".release"}, 64'({out_valid, in_ready, busy, pass_idx}), 64'b010000);
    endtask

    logic [63:0] rv [4];
    logic        ro [4];
    bit          rdy;
    int          acc, got, cyc, last_acc;

    initial begin
        #12;
        check("reset.flags", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset.pass", 64'(pass_idx), 64'd0);
        check("reset.data", out_data, 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: descending input sorted ascending
        send("t1", mk(8, 7, 6, 5, 4, 3, 2, 1), 1'b0, mk(1, 2, 3, 4, 5, 6, 7, 8));
        recv("t1", 1'b0);

        // 2: descending order, then a mixed vector with duplicates and extremes
        send("t2a", mk(8, 7, 6, 5, 4, 3, 2, 1), 1'b1, mk(8, 7, 6, 5, 4, 3, 2, 1));
        recv("t2a", 1'b0);
        send("t2b", mk(3, 200, 0, 255, 17, 17, 9, 128), 1'b0,
             mk(0, 3, 9, 17, 17, 128, 200, 255));
        recv("t2b", 1'b0);

        // 3: all-equal elements pass through untouched
        send("t3", {8{8'hA5}}, 1'b0, {8{8'hA5}});
        recv("t3", 1'b0);

        // 4: consumer stalls for three cycles in DONE
        send("t4", mk(5, 1, 4, 2, 8, 6, 7, 3), 1'b1, mk(8, 7, 6, 5, 4, 3, 2, 1));
        recv("t4", 1'b1);

        // 5: asynchronous reset while pass 3 is in flight
        send("t5", mk(9, 9, 1, 2, 250, 3, 0, 4), 1'b0, 64'd0);
        repeat (3) tick();
        check("t5.pass3", 64'(pass_idx), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t5.rst_flags", 64'({out_valid, busy, in_ready}), 64'b001);
        check("t5.rst_pass", 64'(pass_idx), 64'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        #2 rst_n = 1'b1;
        tick();
        send("t5b", mk(40, 30, 20, 10, 70, 60, 50, 45), 1'b0,
             mk(10, 20, 30, 40, 45, 50, 60, 70));
        recv("t5b", 1'b0);

        // 6: in_valid held high, out_ready tied high, back-to-back random vectors
        for (int i = 0; i < 4; i++) begin
            rv[i] = {$urandom(), $urandom()};
            ro[i] = 1'($urandom_range(0, 1));
        end
        acc = 0; got = 0; cyc = 0; last_acc = 0;
        out_ready = 1'b1;
        in_data   = rv[0];
        in_order  = ro[0];
        in_valid  = 1'b1;
        while (got < 4 && cyc < 100) begin
            rdy = in_ready;
            tick();
            cyc++;
            if (rdy && in_valid) begin
                if (acc > 0) check("t6.spacing", 64'(cyc - last_acc), 64'd8);
                last_acc = cyc;
                exp_q.push_back(ref_sort(rv[acc], ro[acc]));
                acc++;
                if (acc < 4) begin
                    in_data  = rv[acc];
                    in_order = ro[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (exp_q.size() > 0) check("t6.data", out_data, exp_q.pop_front());
                else check("t6.unexpected", out_data, 64'hx);
                got++;
            end
        end
        check("t6.count", 64'(got), 64'd4);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
